// File: rtl/out_mem_ctrl.sv
// Output-memory controller: arbitrates block writes, block reads and zero-fill
// clears onto one LANES-wide memory port, tracking written and read blocks.
module out_mem_ctrl #(
    parameter int DEPTH = 128,
    parameter int LANES = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_req,
    input  logic [LANES*32-1:0] wr_data,
    output logic                wr_ack,
    input  logic                rd_req,
    output logic                rd_ack,
    output logic                rd_valid,
    output logic [LANES*32-1:0] rd_data,
    input  logic                clr,
    output logic [31:0]         mem_addr,
    output logic                mem_we,
    output logic [LANES*32-1:0] mem_wd,
    input  logic [LANES*32-1:0] mem_rd,
    output logic [5:0]          blk_cnt,
    output logic                full,
    output logic                empty,
    output logic                busy
);

    localparam logic [5:0]  NBLK = 6'(DEPTH / LANES);
    localparam logic [5:0]  LAST = NBLK - 6'd1;
    localparam logic [31:0] STEP = 32'(LANES);

    typedef enum logic [1:0] {IDLE, WRITE, READ, CLEAR} state_t;

    state_t      state;
    state_t      next_state;
    logic [5:0]  rd_cnt;
    logic [5:0]  clr_idx;
    logic        rr_wr;
    logic        wr_ok;
    logic        rd_ok;
    logic [31:0] blk_addr;
    logic [31:0] rd_addr;

    assign full     = (blk_cnt == NBLK);
    assign empty    = (rd_cnt == blk_cnt);
    assign busy     = (state != IDLE);
    assign wr_ok    = wr_req && !full;
    assign rd_ok    = rd_req && !empty;
    assign blk_addr = 32'(blk_cnt) * STEP;
    assign rd_addr  = 32'(rd_cnt) * STEP;

    // Grants are decided combinationally in IDLE so the ack lands on the grant cycle.
    always_comb begin
        next_state = state;
        wr_ack     = 1'b0;
        rd_ack     = 1'b0;
        case (state)
            IDLE: begin
                if (rst) begin
                    if (clr) begin
                        next_state = CLEAR;
                    end else if (wr_ok && (!rd_ok || rr_wr)) begin
                        wr_ack     = 1'b1;
                        next_state = WRITE;
                    end else if (rd_ok) begin
                        rd_ack     = 1'b1;
                        next_state = READ;
                    end
                end
            end
            WRITE:   next_state = IDLE;
            READ:    next_state = IDLE;
            CLEAR:   if (clr_idx == LAST) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            mem_we   <= 1'b0;
            mem_addr <= '0;
            mem_wd   <= '0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
            blk_cnt  <= '0;
            rd_cnt   <= '0;
            clr_idx  <= '0;
            rr_wr    <= 1'b1;
        end else begin
            state    <= next_state;
            rd_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (wr_ack) begin
                        mem_addr <= blk_addr;
                        mem_wd   <= wr_data;
                        mem_we   <= 1'b1;
                    end else if (rd_ack) begin
                        mem_addr <= rd_addr;
                        mem_we   <= 1'b0;
                    end else if (next_state == CLEAR) begin
                        mem_addr <= '0;
                        mem_wd   <= '0;
                        mem_we   <= 1'b1;
                        clr_idx  <= '0;
                    end
                    // The round-robin pointer only moves when both sides actually compete.
                    if (wr_ok && rd_ok && !clr) rr_wr <= !rr_wr;
                end
                WRITE: begin
                    mem_we  <= 1'b0;
                    blk_cnt <= blk_cnt + 6'd1;
                end
                READ: begin
                    rd_data  <= mem_rd;
                    rd_valid <= 1'b1;
                    rd_cnt   <= rd_cnt + 6'd1;
                end
                CLEAR: begin
                    if (clr_idx == LAST) begin
                        mem_we  <= 1'b0;
                        blk_cnt <= '0;
                        rd_cnt  <= '0;
                        rr_wr   <= 1'b1;
                    end else begin
                        clr_idx  <= clr_idx + 6'd1;
                        mem_addr <= mem_addr + STEP;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_out_mem_ctrl.sv
// Bench for out_mem_ctrl: directed scenarios and random traffic compared
// against a transaction-level model of grants, block counts and stored data.
module tb_out_mem_ctrl;
    localparam int DEPTH = 128;
    localparam int LANES = 4;
    localparam int NBLK  = DEPTH / LANES;
    localparam int W     = LANES * 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         wr_req;
    logic [W-1:0] wr_data;
    logic         wr_ack;
    logic         rd_req;
    logic         rd_ack;
    logic         rd_valid;
    logic [W-1:0] rd_data;
    logic         clr;
    logic [31:0]  mem_addr;
    logic         mem_we;
    logic [W-1:0] mem_wd;
    logic [W-1:0] mem_rd;
    logic [5:0]   blk_cnt;
    logic         full;
    logic         empty;
    logic         busy;

    int n_checks = 0;
    int n_pass   = 0;

    out_mem_ctrl #(.DEPTH(DEPTH), .LANES(LANES)) dut (
        .clk(clk), .rst(rst), .wr_req(wr_req), .wr_data(wr_data), .wr_ack(wr_ack),
        .rd_req(rd_req), .rd_ack(rd_ack), .rd_valid(rd_valid), .rd_data(rd_data),
        .clr(clr), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wd(mem_wd),
        .mem_rd(mem_rd), .blk_cnt(blk_cnt), .full(full), .empty(empty), .busy(busy)
    );

    always #5 clk = ~clk;

    // Memory attached to the controller: combinational read, clocked write.
    logic [W-1:0] tb_mem [0:NBLK-1];
    assign mem_rd = tb_mem[mem_addr[6:2]];
    always @(posedge clk) if (mem_we === 1'b1) tb_mem[mem_addr[6:2]] <= mem_wd;

    // Reference model: an operation occupies the port for m_busy cycles.
    int           m_blk, m_rdc, m_busy, m_op;
    bit           m_rr_wr;
    logic         m_we, m_rd_valid;
    logic [31:0]  m_addr;
    logic [W-1:0] m_wd, m_rd_data;
    logic [W-1:0] m_store [0:NBLK-1];

    // 0 none, 1 write, 2 read, 3 clear
    function automatic int m_grant();
        bit we, re;
        if (rst !== 1'b1 || m_busy != 0) return 0;
        if (clr) return 3;
        we = wr_req && (m_blk < NBLK);
        re = rd_req && (m_rdc < m_blk);
        if (we && re) return m_rr_wr ? 1 : 2;
        if (we) return 1;
        if (re) return 2;
        return 0;
    endfunction

    task automatic model_step();
        int g;
        g = m_grant();
        m_rd_valid = 1'b0;
        if (rst !== 1'b1) begin
            m_blk = 0; m_rdc = 0; m_busy = 0; m_op = 0; m_rr_wr = 1'b1;
            m_we = 1'b0; m_addr = '0; m_wd = '0; m_rd_data = '0;
        end else if (m_busy == 0) begin
            if (!clr && wr_req && rd_req && m_blk < NBLK && m_rdc < m_blk) m_rr_wr = (g == 2);
            case (g)
                1: begin
                    m_addr = 32'(m_blk * LANES); m_we = 1'b1; m_wd = wr_data;
                    m_store[m_blk] = wr_data; m_busy = 1; m_op = 1;
                end
                2: begin m_addr = 32'(m_rdc * LANES); m_we = 1'b0; m_busy = 1; m_op = 2; end
                3: begin m_addr = '0; m_we = 1'b1; m_wd = '0; m_busy = NBLK; m_op = 3; end
                default: m_we = 1'b0;
            endcase
        end else begin
            case (m_op)
                1: begin m_blk++; m_we = 1'b0; m_busy = 0; end
                2: begin m_rd_data = m_store[m_rdc]; m_rd_valid = 1'b1; m_rdc++; m_busy = 0; end
                default: begin
                    m_busy--;
                    if (m_busy == 0) begin
                        m_blk = 0; m_rdc = 0; m_rr_wr = 1'b1; m_we = 1'b0;
                    end else begin
                        m_addr = m_addr + 32'(LANES);
                    end
                end
            endcase
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    function automatic logic [W-1:0] rand_blk();
        logic [W-1:0] r;
        for (int k = 0; k < LANES; k++) r[k*32 +: 32] = $urandom();
        return r;
    endfunction

    task automatic test_reset();
        rst = 1'b0; wr_req = 1'b0; rd_req = 1'b0; clr = 1'b0; wr_data = '0;
        repeat (2) tick();
        #2;
        n_checks++; if (mem_we !== 1'b0) $display("FAIL reset_mem_we: got %0b want 0", mem_we); else n_pass++;
        n_checks++; if (mem_addr !== 32'd0) $display("FAIL reset_mem_addr: got %0h want 0", mem_addr); else n_pass++;
        n_checks++; if (mem_wd !== '0) $display("FAIL reset_mem_wd: got %0h want 0", mem_wd); else n_pass++;
        n_checks++; if (wr_ack !== 1'b0) $display("FAIL reset_wr_ack: got %0b want 0", wr_ack); else n_pass++;
        n_checks++; if (rd_ack !== 1'b0) $display("FAIL reset_rd_ack: got %0b want 0", rd_ack); else n_pass++;
        n_checks++; if (rd_valid !== 1'b0) $display("FAIL reset_rd_valid: got %0b want 0", rd_valid); else n_pass++;
        n_checks++; if (rd_data !== '0) $display("FAIL reset_rd_data: got %0h want 0", rd_data); else n_pass++;
        n_checks++; if (blk_cnt !== 6'd0) $display("FAIL reset_blk_cnt: got %0d want 0", blk_cnt); else n_pass++;
        n_checks++; if (full !== 1'b0) $display("FAIL reset_full: got %0b want 0", full); else n_pass++;
        n_checks++; if (empty !== 1'b1) $display("FAIL reset_empty: got %0b want 1", empty); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %0b want 0", busy); else n_pass++;
        rst = 1'b1; rd_req = 1'b1;
        #2;
        n_checks++; if (rd_ack !== 1'b0) $display("FAIL empty_rd_ack: got %0b want 0", rd_ack); else n_pass++;
        tick();
        #2;
        n_checks++; if (busy !== 1'b0) $display("FAIL empty_rd_busy: got %0b want 0", busy); else n_pass++;
        rd_req = 1'b0;
        tick();
    endtask

    task automatic test_write_read();
        logic [W-1:0] d;
        d = {32'd4, 32'd3, 32'd2, 32'd1};
        wr_data = d; wr_req = 1'b1;
        #2;
        n_checks++; if (wr_ack !== 1'b1) $display("FAIL wr_grant_ack: got %0b want 1", wr_ack); else n_pass++;
        tick();
        wr_req = 1'b0;
        #2;
        n_checks++; if (mem_we !== 1'b1) $display("FAIL wr_mem_we: got %0b want 1", mem_we); else n_pass++;
        n_checks++; if (mem_addr !== 32'd0) $display("FAIL wr_mem_addr: got %0h want 0", mem_addr); else n_pass++;
        n_checks++; if (mem_wd !== d) $display("FAIL wr_mem_wd: got %0h want %0h", mem_wd, d); else n_pass++;
        n_checks++; if (busy !== 1'b1) $display("FAIL wr_busy: got %0b want 1", busy); else n_pass++;
        tick();
        #2;
        n_checks++; if (mem_we !== 1'b0) $display("FAIL wr_done_we: got %0b want 0", mem_we); else n_pass++;
        n_checks++; if (blk_cnt !== 6'd1) $display("FAIL wr_blk_cnt: got %0d want 1", blk_cnt); else n_pass++;
        n_checks++; if (empty !== 1'b0) $display("FAIL wr_empty: got %0b want 0", empty); else n_pass++;
        rd_req = 1'b1;
        #2;
        n_checks++; if (rd_ack !== 1'b1) $display("FAIL rd_grant_ack: got %0b want 1", rd_ack); else n_pass++;
        tick();
        rd_req = 1'b0;
        #2;
        n_checks++; if (mem_we !== 1'b0) $display("FAIL rd_mem_we: got %0b want 0", mem_we); else n_pass++;
        n_checks++; if (mem_addr !== 32'd0) $display("FAIL rd_mem_addr: got %0h want 0", mem_addr); else n_pass++;
        n_checks++; if (rd_valid !== 1'b0) $display("FAIL rd_valid_early: got %0b want 0", rd_valid); else n_pass++;
        tick();
        #2;
        n_checks++; if (rd_valid !== 1'b1) $display("FAIL rd_valid: got %0b want 1", rd_valid); else n_pass++;
        n_checks++; if (rd_data !== d) $display("FAIL rd_data: got %0h want %0h", rd_data, d); else n_pass++;
        n_checks++; if (empty !== 1'b1) $display("FAIL rd_empty: got %0b want 1", empty); else n_pass++;
        tick();
        #2;
        n_checks++; if (rd_valid !== 1'b0) $display("FAIL rd_valid_pulse: got %0b want 0", rd_valid); else n_pass++;
        n_checks++; if (rd_data !== d) $display("FAIL rd_data_hold: got %0h want %0h", rd_data, d); else n_pass++;
    endtask

    task automatic test_fill();
        logic [W-1:0] saved [0:NBLK-1];
        rst = 1'b0; tick(); rst = 1'b1;
        wr_req = 1'b1;
        for (int i = 0; i < NBLK; i++) begin
            saved[i] = rand_blk();
            wr_data = saved[i];
            #2;
            n_checks++; if (wr_ack !== 1'b1) $display("FAIL fill_ack[%0d]: got %0b want 1", i, wr_ack); else n_pass++;
            tick();
            #2;
            n_checks++; if (mem_we !== 1'b1) $display("FAIL fill_we[%0d]: got %0b want 1", i, mem_we); else n_pass++;
            n_checks++; if (mem_addr !== 32'(i * LANES)) $display("FAIL fill_addr[%0d]: got %0d want %0d", i, mem_addr, i * LANES); else n_pass++;
            n_checks++; if (mem_wd !== saved[i]) $display("FAIL fill_wd[%0d]: got %0h want %0h", i, mem_wd, saved[i]); else n_pass++;
            n_checks++; if (wr_ack !== 1'b0) $display("FAIL fill_busy_ack[%0d]: got %0b want 0", i, wr_ack); else n_pass++;
            tick();
        end
        #2;
        n_checks++; if (blk_cnt !== 6'd32) $display("FAIL fill_blk_cnt: got %0d want 32", blk_cnt); else n_pass++;
        n_checks++; if (full !== 1'b1) $display("FAIL fill_full: got %0b want 1", full); else n_pass++;
        n_checks++; if (wr_ack !== 1'b0) $display("FAIL full_ack: got %0b want 0", wr_ack); else n_pass++;
        repeat (2) begin
            tick();
            #2;
            n_checks++; if (mem_we !== 1'b0) $display("FAIL full_we: got %0b want 0", mem_we); else n_pass++;
            n_checks++; if (busy !== 1'b0) $display("FAIL full_busy: got %0b want 0", busy); else n_pass++;
            n_checks++; if (mem_addr > 32'd124) $display("FAIL full_addr: got %0d want <=124", mem_addr); else n_pass++;
        end
        wr_req = 1'b0; rd_req = 1'b1;
        for (int j = 0; j < 3; j++) begin
            #2;
            n_checks++; if (rd_ack !== 1'b1) $display("FAIL fill_rd_ack[%0d]: got %0b want 1", j, rd_ack); else n_pass++;
            tick();
            tick();
            #2;
            n_checks++; if (rd_data !== saved[j]) $display("FAIL fill_rd_data[%0d]: got %0h want %0h", j, rd_data, saved[j]); else n_pass++;
        end
        rd_req = 1'b0;
        tick();
    endtask

    task automatic test_contention();
        int grants[$];
        int e;
        rst = 1'b0; tick(); rst = 1'b1;
        wr_req = 1'b1;
        repeat (4) begin wr_data = rand_blk(); tick(); end
        rd_req = 1'b1;
        for (int c = 0; c < 140; c++) begin
            wr_data = rand_blk();
            #2;
            e = m_grant();
            if (e != 0) grants.push_back(e);
            n_checks++; if (wr_ack !== (e == 1)) $display("FAIL cont_wr_ack[%0d]: got %0b want %0b", c, wr_ack, e == 1); else n_pass++;
            n_checks++; if (rd_ack !== (e == 2)) $display("FAIL cont_rd_ack[%0d]: got %0b want %0b", c, rd_ack, e == 2); else n_pass++;
            if (empty === 1'b1) begin
                n_checks++; if (rd_ack !== 1'b0) $display("FAIL cont_rd_empty[%0d]: got %0b want 0", c, rd_ack); else n_pass++;
            end
            if (m_rd_valid) begin
                n_checks++; if (rd_data !== m_rd_data) $display("FAIL cont_rd_data[%0d]: got %0h want %0h", c, rd_data, m_rd_data); else n_pass++;
            end
            tick();
        end
        n_checks++; if (grants.size() < 6) $display("FAIL cont_grant_count: got %0d want >=6", grants.size()); else n_pass++;
        for (int i = 0; i < 6 && i < grants.size(); i++) begin
            n_checks++; if (grants[i] != ((i % 2 == 0) ? 1 : 2)) $display("FAIL cont_order[%0d]: got %0d want %0d", i, grants[i], (i % 2 == 0) ? 1 : 2); else n_pass++;
        end
        #2;
        n_checks++; if (full !== 1'b1) $display("FAIL cont_end_full: got %0b want 1", full); else n_pass++;
        n_checks++; if (empty !== 1'b1) $display("FAIL cont_end_empty: got %0b want 1", empty); else n_pass++;
        wr_req = 1'b0; rd_req = 1'b0;
        tick();
    endtask

    task automatic test_clear();
        logic [W-1:0] d0, d1;
        d0 = rand_blk(); d1 = rand_blk();
        rst = 1'b0; tick(); rst = 1'b1;
        wr_req = 1'b1; wr_data = d0;
        #2;
        n_checks++; if (wr_ack !== 1'b1) $display("FAIL clr_setup_ack0: got %0b want 1", wr_ack); else n_pass++;
        tick();
        wr_data = d1;
        tick();
        #2;
        n_checks++; if (wr_ack !== 1'b1) $display("FAIL clr_setup_ack1: got %0b want 1", wr_ack); else n_pass++;
        tick();
        wr_req = 1'b0;
        tick();
        rd_req = 1'b1;
        #2;
        n_checks++; if (rd_ack !== 1'b1) $display("FAIL clr_rd_ack: got %0b want 1", rd_ack); else n_pass++;
        tick();
        rd_req = 1'b0; clr = 1'b1; wr_req = 1'b1;
        #2;
        n_checks++; if (busy !== 1'b1) $display("FAIL clr_in_read_busy: got %0b want 1", busy); else n_pass++;
        tick();
        #2;
        n_checks++; if (rd_valid !== 1'b1) $display("FAIL clr_rd_valid: got %0b want 1", rd_valid); else n_pass++;
        n_checks++; if (rd_data !== d0) $display("FAIL clr_rd_data: got %0h want %0h", rd_data, d0); else n_pass++;
        n_checks++; if (wr_ack !== 1'b0) $display("FAIL clr_grant_wr_ack: got %0b want 0", wr_ack); else n_pass++;
        tick();
        clr = 1'b0;
        for (int k = 0; k < NBLK; k++) begin
            #2;
            n_checks++; if (busy !== 1'b1) $display("FAIL clr_busy[%0d]: got %0b want 1", k, busy); else n_pass++;
            n_checks++; if (mem_we !== 1'b1) $display("FAIL clr_we[%0d]: got %0b want 1", k, mem_we); else n_pass++;
            n_checks++; if (mem_wd !== '0) $display("FAIL clr_wd[%0d]: got %0h want 0", k, mem_wd); else n_pass++;
            n_checks++; if (mem_addr !== 32'(k * LANES)) $display("FAIL clr_addr[%0d]: got %0d want %0d", k, mem_addr, k * LANES); else n_pass++;
            n_checks++; if (wr_ack !== 1'b0) $display("FAIL clr_wr_ack[%0d]: got %0b want 0", k, wr_ack); else n_pass++;
            tick();
        end
        #2;
        n_checks++; if (busy !== 1'b0) $display("FAIL clr_end_busy: got %0b want 0", busy); else n_pass++;
        n_checks++; if (mem_we !== 1'b0) $display("FAIL clr_end_we: got %0b want 0", mem_we); else n_pass++;
        n_checks++; if (blk_cnt !== 6'd0) $display("FAIL clr_end_blk_cnt: got %0d want 0", blk_cnt); else n_pass++;
        n_checks++; if (empty !== 1'b1) $display("FAIL clr_end_empty: got %0b want 1", empty); else n_pass++;
        n_checks++; if (rd_data !== d0) $display("FAIL clr_rd_hold: got %0h want %0h", rd_data, d0); else n_pass++;
        n_checks++; if (wr_ack !== 1'b1) $display("FAIL clr_pending_wr: got %0b want 1", wr_ack); else n_pass++;
        tick();
        wr_req = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_clear();
        rst = 1'b0; tick(); rst = 1'b1;
        wr_req = 1'b1;
        repeat (6) begin wr_data = rand_blk(); tick(); end
        wr_req = 1'b0; clr = 1'b1;
        tick();
        clr = 1'b0;
        repeat (10) tick();
        #2;
        n_checks++; if (busy !== 1'b1) $display("FAIL mid_clr_busy: got %0b want 1", busy); else n_pass++;
        n_checks++; if (mem_addr !== 32'd40) $display("FAIL mid_clr_addr: got %0d want 40", mem_addr); else n_pass++;
        n_checks++; if (blk_cnt !== 6'd3) $display("FAIL mid_clr_blk_cnt: got %0d want 3", blk_cnt); else n_pass++;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        #2;
        n_checks++; if (busy !== 1'b0) $display("FAIL mid_rst_busy: got %0b want 0", busy); else n_pass++;
        n_checks++; if (mem_we !== 1'b0) $display("FAIL mid_rst_we: got %0b want 0", mem_we); else n_pass++;
        n_checks++; if (blk_cnt !== 6'd0) $display("FAIL mid_rst_blk_cnt: got %0d want 0", blk_cnt); else n_pass++;
        n_checks++; if (empty !== 1'b1) $display("FAIL mid_rst_empty: got %0b want 1", empty); else n_pass++;
        tick();
    endtask

    task automatic test_random();
        int e;
        for (int c = 0; c < 800; c++) begin
            wr_req  = ($urandom_range(0, 3) != 0);
            rd_req  = ($urandom_range(0, 3) != 0);
            clr     = ($urandom_range(0, 59) == 0);
            rst     = ($urandom_range(0, 199) != 0);
            wr_data = rand_blk();
            #2;
            e = m_grant();
            n_checks++; if (wr_ack !== (e == 1)) $display("FAIL rnd_wr_ack[%0d]: got %0b want %0b", c, wr_ack, e == 1); else n_pass++;
            n_checks++; if (rd_ack !== (e == 2)) $display("FAIL rnd_rd_ack[%0d]: got %0b want %0b", c, rd_ack, e == 2); else n_pass++;
            n_checks++; if (mem_we !== m_we) $display("FAIL rnd_we[%0d]: got %0b want %0b", c, mem_we, m_we); else n_pass++;
            n_checks++; if (mem_addr !== m_addr) $display("FAIL rnd_addr[%0d]: got %0d want %0d", c, mem_addr, m_addr); else n_pass++;
            n_checks++; if (mem_wd !== m_wd) $display("FAIL rnd_wd[%0d]: got %0h want %0h", c, mem_wd, m_wd); else n_pass++;
            n_checks++; if (rd_valid !== m_rd_valid) $display("FAIL rnd_rd_valid[%0d]: got %0b want %0b", c, rd_valid, m_rd_valid); else n_pass++;
            n_checks++; if (rd_data !== m_rd_data) $display("FAIL rnd_rd_data[%0d]: got %0h want %0h", c, rd_data, m_rd_data); else n_pass++;
            n_checks++; if (blk_cnt !== 6'(m_blk)) $display("FAIL rnd_blk_cnt[%0d]: got %0d want %0d", c, blk_cnt, m_blk); else n_pass++;
            n_checks++; if (full !== (m_blk == NBLK)) $display("FAIL rnd_full[%0d]: got %0b want %0b", c, full, m_blk == NBLK); else n_pass++;
            n_checks++; if (empty !== (m_rdc == m_blk)) $display("FAIL rnd_empty[%0d]: got %0b want %0b", c, empty, m_rdc == m_blk); else n_pass++;
            n_checks++; if (busy !== (m_busy != 0)) $display("FAIL rnd_busy[%0d]: got %0b want %0b", c, busy, m_busy != 0); else n_pass++;
            tick();
        end
        rst = 1'b1; wr_req = 1'b0; rd_req = 1'b0; clr = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_fill();
        test_contention();
        test_clear();
        test_reset_mid_clear();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
